// File: rtl/dm_access_arbiter.sv
// Data-memory sequencer and core/host arbiter, including write-data delay and bypass-coherent bc_dt.
// Optional host anti-starvation aging is enabled by defining DM_ARB_AGING_EN.
module dm_access_arbiter #(
  parameter int DMA_SIZE = 3,
  parameter int DMD_SIZE = 4,
  parameter int AGE_MAX  = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                c_req,
  input  logic                c_wr,
  input  logic [DMA_SIZE-1:0] c_addr,
  input  logic [DMD_SIZE-1:0] c_wdata,
  input  logic                h_req,
  input  logic                h_wr,
  input  logic [DMA_SIZE-1:0] h_addr,
  input  logic [DMD_SIZE-1:0] h_wdata,
  output logic                c_gnt,
  output logic                h_gnt,
  output logic                c_rvalid,
  output logic                h_rvalid,
  output logic [DMD_SIZE-1:0] c_rdata,
  output logic [DMD_SIZE-1:0] h_rdata,
  output logic                ps_dm_cslt,
  output logic                ps_dm_wrb,
  output logic [DMA_SIZE-1:0] dg_dm_add,
  output logic [DMD_SIZE-1:0] bc_dt,
  input  logic [DMD_SIZE-1:0] dm_bc_dt
);

  typedef enum logic [1:0] {INIT0, INIT1, RUN} state_t;
  typedef enum logic [1:0] {PH_NONE, PH_WD, PH_RD} phase_t;

  state_t              state, state_next;
  phase_t              phase, phase_next;
  logic                rd_core, rd_core_next;
  logic                rd_host, rd_host_next;
  logic [DMD_SIZE-1:0] wdata_q, wdata_next;
  logic [DMD_SIZE-1:0] shadow;
  logic [DMA_SIZE-1:0] last_addr;
  logic                host_prio;

`ifdef DM_ARB_AGING_EN
  logic [7:0] age;

  assign host_prio = h_req && (age == 8'(AGE_MAX));

  always_ff @(posedge clk) begin
    if (!reset) begin
      age <= 8'd0;
    end else if (state == RUN) begin
      if (h_gnt) begin
        age <= 8'd0;
      end else if (h_req) begin
        age <= age + 8'd1;
      end
    end
  end
`else
  assign host_prio = 1'b0;
`endif

  assign c_rdata = dm_bc_dt;
  assign h_rdata = dm_bc_dt;

  always_comb begin
    state_next   = state;
    phase_next   = PH_NONE;
    rd_core_next = 1'b0;
    rd_host_next = 1'b0;
    wdata_next   = wdata_q;
    c_gnt        = 1'b0;
    h_gnt        = 1'b0;
    ps_dm_cslt   = 1'b0;
    ps_dm_wrb    = 1'b0;
    dg_dm_add    = last_addr;
    bc_dt        = shadow;
    c_rvalid     = rd_core;
    h_rvalid     = rd_host;

    case (state)
      INIT0: begin
        dg_dm_add  = DMA_SIZE'(1);
        state_next = INIT1;
      end
      INIT1: begin
        ps_dm_cslt = 1'b1;
        dg_dm_add  = '0;
        phase_next = PH_RD;
        state_next = RUN;
      end
      RUN: begin
        c_gnt = c_req && !host_prio;
        h_gnt = h_req && !c_gnt;
        if (c_gnt) begin
          ps_dm_cslt = 1'b1;
          ps_dm_wrb  = c_wr;
          dg_dm_add  = c_addr;
          if (c_wr) begin
            phase_next = PH_WD;
            wdata_next = c_wdata;
          end else begin
            phase_next   = PH_RD;
            rd_core_next = 1'b1;
          end
        end else if (h_gnt) begin
          ps_dm_cslt = 1'b1;
          ps_dm_wrb  = h_wr;
          dg_dm_add  = h_addr;
          if (h_wr) begin
            phase_next = PH_WD;
            wdata_next = h_wdata;
          end else begin
            phase_next   = PH_RD;
            rd_host_next = 1'b1;
          end
        end
      end
      default: state_next = INIT0;
    endcase

    // Shadow tracks whatever the DM will bypass back on a same-address access.
    case (phase)
      PH_WD:   bc_dt = wdata_q;
      PH_RD:   bc_dt = dm_bc_dt;
      default: bc_dt = shadow;
    endcase

    // Outputs are forced quiet for the whole time reset is held, including its first cycle.
    if (!reset) begin
      c_gnt      = 1'b0;
      h_gnt      = 1'b0;
      c_rvalid   = 1'b0;
      h_rvalid   = 1'b0;
      ps_dm_cslt = 1'b0;
      ps_dm_wrb  = 1'b0;
      dg_dm_add  = '0;
      bc_dt      = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= INIT0;
      phase     <= PH_NONE;
      rd_core   <= 1'b0;
      rd_host   <= 1'b0;
      wdata_q   <= '0;
      shadow    <= '0;
      last_addr <= '0;
    end else begin
      state     <= state_next;
      phase     <= phase_next;
      rd_core   <= rd_core_next;
      rd_host   <= rd_host_next;
      wdata_q   <= wdata_next;
      shadow    <= bc_dt;
      last_addr <= dg_dm_add;
    end
  end

endmodule

// File: tb/tb_dm_access_arbiter.sv
// Directed bench for dm_access_arbiter with a small behavioural DM (registered read,
// address-match bypass, write committed one cycle after the strobe).
module tb_dm_access_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic       c_req, c_wr, h_req, h_wr;
  logic [2:0] c_addr, h_addr;
  logic [3:0] c_wdata, h_wdata;
  logic       c_gnt, h_gnt, c_rvalid, h_rvalid;
  logic [3:0] c_rdata, h_rdata;
  logic       ps_dm_cslt, ps_dm_wrb;
  logic [2:0] dg_dm_add;
  logic [3:0] bc_dt;
  logic [3:0] dm_bc_dt;

  int error_count = 0;
  int check_count = 0;

  always #5 clk = ~clk;

  dm_access_arbiter #(.DMA_SIZE(3), .DMD_SIZE(4), .AGE_MAX(4)) dut (
    .clk(clk), .reset(reset),
    .c_req(c_req), .c_wr(c_wr), .c_addr(c_addr), .c_wdata(c_wdata),
    .h_req(h_req), .h_wr(h_wr), .h_addr(h_addr), .h_wdata(h_wdata),
    .c_gnt(c_gnt), .h_gnt(h_gnt), .c_rvalid(c_rvalid), .h_rvalid(h_rvalid),
    .c_rdata(c_rdata), .h_rdata(h_rdata),
    .ps_dm_cslt(ps_dm_cslt), .ps_dm_wrb(ps_dm_wrb), .dg_dm_add(dg_dm_add),
    .bc_dt(bc_dt), .dm_bc_dt(dm_bc_dt)
  );

  // Behavioural DM; array starts as mem[i] = i + 8.
  logic [3:0] mem [8];
  logic [2:0] lat_addr = 3'd0;
  logic [2:0] wr_addr  = 3'd0;
  logic       wr_pend  = 1'b0;
  logic [3:0] dm_rd    = 4'd0;

  assign dm_bc_dt = dm_rd;

  initial begin
    for (int i = 0; i < 8; i++) mem[i] = 4'(i + 8);
  end

  always @(posedge clk) begin
    if (wr_pend) mem[wr_addr] <= bc_dt;
    wr_pend <= ps_dm_cslt & ps_dm_wrb;
    wr_addr <= dg_dm_add;
    if (ps_dm_cslt && !ps_dm_wrb)
      dm_rd <= (dg_dm_add == lat_addr) ? bc_dt : mem[dg_dm_add];
    lat_addr <= dg_dm_add;
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    check_count++;
    if (actual !== expected) begin
      error_count++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic cr, input logic cw, input logic [2:0] ca, input logic [3:0] cd,
                               input logic hr, input logic hw, input logic [2:0] ha, input logic [3:0] hd);
    c_req = cr; c_wr = cw; c_addr = ca; c_wdata = cd;
    h_req = hr; h_wr = hw; h_addr = ha; h_wdata = hd;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    @(negedge clk);
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_c_gnt"}, 32'(c_gnt), 0);
    checkOutput({tag, "_h_gnt"}, 32'(h_gnt), 0);
    checkOutput({tag, "_c_rvalid"}, 32'(c_rvalid), 0);
    checkOutput({tag, "_h_rvalid"}, 32'(h_rvalid), 0);
    checkOutput({tag, "_cslt"}, 32'(ps_dm_cslt), 0);
    checkOutput({tag, "_wrb"}, 32'(ps_dm_wrb), 0);
    checkOutput({tag, "_addr"}, 32'(dg_dm_add), 0);
    checkOutput({tag, "_bc_dt"}, 32'(bc_dt), 0);
  endtask

  initial begin
    logic exp_h;
    reset = 1'b0;
    applyStimulus(1, 0, 3'd0, 4'd0, 1, 0, 3'd0, 4'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkResetState("rst");

    @(posedge clk); #1;
    reset = 1'b1;
    applyStimulus(1, 0, 3'd0, 4'd0, 0, 0, 3'd0, 4'd0);
    @(negedge clk);
    checkOutput("init0_addr", 32'(dg_dm_add), 1);
    checkOutput("init0_cslt", 32'(ps_dm_cslt), 0);
    checkOutput("init0_c_gnt", 32'(c_gnt), 0);
    step();
    checkOutput("init1_addr", 32'(dg_dm_add), 0);
    checkOutput("init1_cslt", 32'(ps_dm_cslt), 1);
    checkOutput("init1_wrb", 32'(ps_dm_wrb), 0);
    checkOutput("init1_c_gnt", 32'(c_gnt), 0);
    step();
    checkOutput("first_c_gnt", 32'(c_gnt), 1);
    checkOutput("first_h_gnt", 32'(h_gnt), 0);
    checkOutput("init_rd_bc_dt", 32'(bc_dt), 8);
    checkOutput("init_rd_no_rvalid", 32'(c_rvalid), 0);

    @(posedge clk); #1;
    applyStimulus(1, 1, 3'd3, 4'hA, 0, 0, 3'd0, 4'd0);
    @(negedge clk);
    checkOutput("rd0_rvalid", 32'(c_rvalid), 1);
    checkOutput("rd0_rdata", 32'(c_rdata), 8);
    checkOutput("wr3_wrb", 32'(ps_dm_wrb), 1);

    @(posedge clk); #1;
    applyStimulus(1, 0, 3'd3, 4'd0, 0, 0, 3'd0, 4'd0);
    @(negedge clk);
    checkOutput("wr3_bc_dt", 32'(bc_dt), 4'hA);
    checkOutput("wr3_no_rvalid", 32'(c_rvalid), 0);

    @(posedge clk); #1;
    applyStimulus(1, 1, 3'd5, 4'h6, 0, 0, 3'd0, 4'd0);
    @(negedge clk);
    checkOutput("raw3_rvalid", 32'(c_rvalid), 1);
    checkOutput("raw3_rdata", 32'(c_rdata), 4'hA);

    @(posedge clk); #1;
    applyStimulus(0, 0, 3'd0, 4'd0, 0, 0, 3'd0, 4'd0);
    @(negedge clk);
    checkOutput("wr5_bc_dt", 32'(bc_dt), 4'h6);
    step();
    checkOutput("idle_cslt", 32'(ps_dm_cslt), 0);
    checkOutput("idle_addr_hold", 32'(dg_dm_add), 5);
    checkOutput("idle_wrb", 32'(ps_dm_wrb), 0);

    @(posedge clk); #1;
    applyStimulus(1, 0, 3'd5, 4'd0, 0, 0, 3'd0, 4'd0);
    @(negedge clk);
    checkOutput("rd5_c_gnt", 32'(c_gnt), 1);
    for (int i = 0; i < 3; i++) begin
      step();
      checkOutput("rd5_rvalid", 32'(c_rvalid), 1);
      checkOutput("rd5_rdata", 32'(c_rdata), 4'h6);
    end

    @(posedge clk); #1;
    applyStimulus(0, 0, 3'd0, 4'd0, 1, 0, 3'd2, 4'd0);
    @(negedge clk);
    checkOutput("rd5_last_rdata", 32'(c_rdata), 4'h6);
    checkOutput("h2_h_gnt", 32'(h_gnt), 1);
    checkOutput("h2_c_gnt", 32'(c_gnt), 0);

    @(posedge clk); #1;
    applyStimulus(1, 0, 3'd2, 4'd0, 0, 0, 3'd0, 4'd0);
    @(negedge clk);
    checkOutput("h2_h_rvalid", 32'(h_rvalid), 1);
    checkOutput("h2_c_rvalid", 32'(c_rvalid), 0);
    checkOutput("h2_h_rdata", 32'(h_rdata), 10);

    @(posedge clk); #1;
    applyStimulus(1, 0, 3'd7, 4'd0, 1, 0, 3'd6, 4'd0);
    @(negedge clk);
    checkOutput("c2_c_rvalid", 32'(c_rvalid), 1);
    checkOutput("c2_h_rvalid", 32'(h_rvalid), 0);
    checkOutput("c2_c_rdata", 32'(c_rdata), 10);

    for (int k = 0; k < 10; k++) begin
`ifdef DM_ARB_AGING_EN
      exp_h = ((k % 5) == 4);
`else
      exp_h = 1'b0;
`endif
      checkOutput($sformatf("cont%0d_h_gnt", k), 32'(h_gnt), 32'(exp_h));
      checkOutput($sformatf("cont%0d_c_gnt", k), 32'(c_gnt), 32'(!exp_h));
      @(posedge clk); #1;
      @(negedge clk);
    end

    @(posedge clk); #1;
    applyStimulus(1, 1, 3'd1, 4'hF, 0, 0, 3'd0, 4'd0);
    @(negedge clk);
    checkOutput("wr1_c_gnt", 32'(c_gnt), 1);
    @(posedge clk); #1;
    reset = 1'b0;
    applyStimulus(1, 0, 3'd1, 4'd0, 1, 0, 3'd1, 4'd0);
    @(negedge clk);
    checkResetState("mid_rst0");
    step();
    checkResetState("mid_rst1");
    @(posedge clk); #1;
    reset = 1'b1;
    applyStimulus(1, 0, 3'd1, 4'd0, 0, 0, 3'd0, 4'd0);
    @(negedge clk);
    checkOutput("re_init0_addr", 32'(dg_dm_add), 1);
    step();
    checkOutput("re_init1_cslt", 32'(ps_dm_cslt), 1);
    step();
    checkOutput("re_rd1_c_gnt", 32'(c_gnt), 1);
    step();
    checkOutput("re_rd1_rvalid", 32'(c_rvalid), 1);
    checkOutput("re_rd1_rdata", 32'(c_rdata), 0);

    $display("Result: errors=%0d of %0d checks", error_count, check_count);
    $finish;
  end

endmodule

// File: doc/dm_access_arbiter.md
# dm_access_arbiter

Sequencer and two-port arbiter for the data memory (DM). It sits between two requesters (processor core, host/debug loader) and the DM port of the `memory` block. It drives `ps_dm_cslt`, `ps_dm_wrb`, `dg_dm_add` and `bc_dt`, and returns read data to the requester that issued the read. The block also performs the DM timing duties that requesters must not see:
- delays write data by one cycle to match the DM's execute+1 write;
- keeps `bc_dt` coherent with the DM's address-match bypass, so every read returns true memory content.

## Interface
- DMA_SIZE, 3, DM address width
- DMD_SIZE, 4, DM data width
- AGE_MAX, 4, host starvation limit in cycles (used only with `DM_ARB_AGING_EN`); range 1..255

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-low reset
- c_req / h_req  in  1  core / host request
- c_wr / h_wr  in  1  1 = write, 0 = read
- c_addr / h_addr  in  DMA_SIZE  request address
- c_wdata / h_wdata  in  DMD_SIZE  write data, valid with the request
- c_gnt / h_gnt  out  1  combinational grant; request is consumed in the cycle it is granted
- c_rvalid / h_rvalid  out  1  read data valid, one cycle after a granted read
- c_rdata / h_rdata  out  DMD_SIZE  `dm_bc_dt` passed through; meaningful only when the matching rvalid is 1
- ps_dm_cslt  out  1  DM chip select
- ps_dm_wrb  out  1  DM write strobe
- dg_dm_add  out  DMA_SIZE  DM address
- bc_dt  out  DMD_SIZE  DM write/bypass data
- dm_bc_dt  in  DMD_SIZE  DM registered read data

## Operation
- **States:** INIT0 → INIT1 → RUN. Reset forces INIT0.
- **INIT0:**
  - cslt=0, dg_dm_add=1, gnt=0.
  - Purpose: forces the DM's latched address to a known non-zero value.
- **INIT1:**
  - cslt=1, wrb=0, dg_dm_add=0, gnt=0.
  - This is an internal read of address 0 that misses the bypass and reads the array.
  - It does not raise rvalid.
- **RUN arbitration:**
  - The core wins whenever c_req=1. The host is granted only when c_req=0.
  - With aging enabled, see Configuration.
  - At most one grant per cycle.
- **Granted op in cycle N:**
  - cslt=1, wrb=c/h_wr, dg_dm_add=addr.
  - For a write, wdata is registered and phase `WD` is set for cycle N+1.
  - For a read, phase `RD` is set for cycle N+1 with the owner's ID.
- **Idle in RUN:** cslt=0, wrb=0, dg_dm_add holds the last issued address.
- **bc_dt selection, every cycle:**
  - `WD` → registered wdata.
  - `RD` (including INIT1's read) → dm_bc_dt.
  - Otherwise → shadow register.
- **Shadow register:** loads the driven bc_dt every cycle. It therefore always holds the current content of the address issued in the previous cycle. This makes DM bypass hits (same address as the previous cycle) return correct data.
- **Read returns:** in cycle N+1, rvalid=1 on the owning port only.
- **Hazards:** read-after-write to the same address in the next cycle returns the new write data through the bypass. No stalls are inserted.

## Timing
- **Reset values:**
  - all gnt=0, all rvalid=0;
  - ps_dm_cslt=0, ps_dm_wrb=0, dg_dm_add=0, bc_dt=0;
  - shadow=0, phase=none, age counter=0.
- **After reset release:** first grant possible in the 3rd cycle (cycles 0 and 1 are INIT0 and INIT1).
- **Latency:** read grant N → rdata/rvalid in N+1. Write grant N → bc_dt=wdata in N+1; DM array updated at the end of N+1.
- **Throughput:** one op per cycle, any read/write mix.
- **Reset during operation:** a write granted in the last cycle before reset assertion completes in DM with data 0, because bc_dt is 0 in reset. Pending rvalid is dropped. INIT restarts.

## Configuration
- **`DM_ARB_AGING_EN` defined:**
  - An 8-bit age counter increments each RUN cycle with h_req=1 and h_gnt=0.
  - When the counter equals AGE_MAX, the host wins over the core for that cycle and c_gnt=0.
  - The counter clears on any host grant.
- **`DM_ARB_AGING_EN` undefined:**
  - Strict core priority; the host can starve.
  - No counter is present. AGE_MAX is ignored.

## Test plan
- **Reset release:** cycle 0 shows dg_dm_add=1, cslt=0. Cycle 1 shows addr=0, cslt=1, wrb=0. Gnt=0 in both cycles. Cycle 2 with c_req read → c_gnt=1.
- **Write then same-address read:** core writes addr 3 = 0xA, core reads addr 3 next cycle → c_rvalid=1 and c_rdata=0xA one cycle later.
- **Write, idle, read:** write addr 5 = 0x6, two idle cycles, read addr 5 → 0x6. Then three back-to-back reads of addr 5 → 0x6 each.
- **Contention:** c_req and h_req held high, both reading, AGE_MAX=4.
  - With the macro: h_gnt on every 5th cycle, c_gnt on the other cycles, never both.
  - Without the macro: h_gnt never asserts.
- **Port steering:** host read of addr 2 while the core is idle → h_rvalid=1, c_rvalid=0. Next cycle a core read of addr 2 → c_rvalid=1 with the same data.
- **Reset mid-operation:** core write of addr 1 = 0xF is granted, reset is asserted the next edge → DM addr 1 reads 0 after re-init. All outputs hold their reset values while reset=0.
